// File: rtl/arb_mux_pkg.sv
// Shared constants, index type and helper functions for the round-robin arbitrated mux.
// The optional packet lock (macro ARB_MUX_LOCK_EN) is handled in rr_arb_mux.
package arb_mux_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  localparam int SEL_W_DEF = clog2(N_CH_DEF);

  typedef logic [SEL_W_DEF-1:0] sel_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching
// upward from ptr with wrap-around.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [SEL_W-1:0] w_cand_idx [N_CH];

  function automatic int wrap_idx(input int v);
    return (v >= N_CH) ? v - N_CH : v;
  endfunction

  // k-th candidate in search order: ptr, ptr+1, ... modulo N_CH
  for (genvar k = 0; k < N_CH; k++) begin : g_cand
    assign w_cand_idx[k] = SEL_W'(wrap_idx(int'(ptr) + k));
  end

  // First requesting candidate wins
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      gnt_idx = (!any_gnt && req[w_cand_idx[k]]) ? w_cand_idx[k] : gnt_idx;
      any_gnt = any_gnt | req[w_cand_idx[k]];
    end
    gnt = any_gnt ? (N_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with a registered valid/ready output stage.
// Define ARB_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int SEL_W  = clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load_en;
  logic              w_xfer;
  logic              w_adv;
  logic              w_any;
  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_gnt;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [DATA_W-1:0] w_gnt_data;

`ifdef ARB_MUX_LOCK_EN
  logic              r_lock;
  logic [SEL_W-1:0]  r_lock_ch;

  assign w_req = r_lock ? (in_valid & (N_CH'(1) << r_lock_ch)) : in_valid;
  assign w_adv = in_last[w_gnt_idx];

  // Lock is taken by a non-final beat and released by the final one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_lock    <= !in_last[w_gnt_idx];
      r_lock_ch <= w_gnt_idx;
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = ^in_last;
  assign w_req         = in_valid;
  assign w_adv         = 1'b1;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (w_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any)
  );

  // in_ready follows out_ready combinationally: no skid buffer behind the output register
  assign w_load_en  = !r_out_valid || out_ready;
  assign w_xfer     = w_any && w_load_en;
  assign in_ready   = w_gnt & {N_CH{w_load_en}};
  assign w_gnt_data = in_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

  // Output register: load on transfer, drain on pop, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_sel   <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Pointer moves past the winner only on a completed transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer && w_adv) begin
      r_ptr <= SEL_W'(next_idx(int'(w_gnt_idx), N_CH));
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
